// File: rtl/data_mem_arbiter_if.sv
// Signal bundle shared by the CPU and debug requesters, the data memory arbiter and the data memory.
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_byte;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_byte;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_read;
    logic              mem_write;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_byte, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_read, mem_write, mem_byte, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_byte, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_read, mem_write, mem_byte, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Registered req/ack engine sharing the data memory between the CPU load/store path and a debug port.
// Tie-break: define DATA_MEM_ARB_RR_EN for round-robin; otherwise the CPU has fixed priority.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e            state_q;
    owner_e            owner_q;
    logic              we_q;
    logic [3:0]        cnt_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_byte_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              cpu_ack_q;
    logic              dbg_ack_q;

    logic              grant_dbg_d;
    logic              sel_we_d;
    logic              sel_byte_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    always_comb begin
        grant_dbg_d = 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
        if (bus.dbg_req && (!bus.cpu_req || owner_q == OWN_CPU)) grant_dbg_d = 1'b1;
`else
        if (bus.dbg_req && !bus.cpu_req) grant_dbg_d = 1'b1;
`endif
        sel_we_d    = grant_dbg_d ? bus.dbg_we    : bus.cpu_we;
        sel_byte_d  = grant_dbg_d ? bus.dbg_byte  : bus.cpu_byte;
        sel_addr_d  = grant_dbg_d ? bus.dbg_addr  : bus.cpu_addr;
        sel_wdata_d = grant_dbg_d ? bus.dbg_wdata : bus.cpu_wdata;
    end

    // Memory outputs are registered, so the IDLE->ISSUE edge loads them for the ISSUE cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DBG;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req || bus.dbg_req) begin
                        owner_q     <= grant_dbg_d ? OWN_DBG : OWN_CPU;
                        we_q        <= sel_we_d;
                        mem_read_q  <= ~sel_we_d;
                        mem_write_q <= sel_we_d;
                        mem_byte_q  <= sel_byte_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        cnt_q       <= CNT_INIT;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        if (owner_q == OWN_DBG) begin
                            dbg_ack_q <= 1'b1;
                            if (!we_q) dbg_rdata_q <= bus.mem_rdata;
                        end else begin
                            cpu_ack_q <= 1'b1;
                            if (!we_q) cpu_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_byte  = mem_byte_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: MEM_LAT=1 instance with a scoreboard, MEM_LAT=3 instance for latency/reset.
module tb_data_mem_arbiter;
    typedef struct {
        bit          is_dbg;
        bit          we;
        bit          byte_op;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int unsigned exp_lat;
        bit          chain;
        int unsigned t0;
    } txn_t;

    logic clock = 1'b0;
    logic rst_n;
    logic rst3_n;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    data_mem_arbiter_if bus1 ();
    data_mem_arbiter_if bus3 ();

    data_mem_arbiter #(.ADDR_W(18), .DATA_W(32), .MEM_LAT(1)) u_dut (
        .clock(clock), .reset_n(rst_n), .bus(bus1)
    );
    data_mem_arbiter #(.ADDR_W(18), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clock(clock), .reset_n(rst3_n), .bus(bus3)
    );

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory models: write on the clock edge, read data presented from the held address.
    logic [31:0] mem1 [logic [17:0]];
    logic [31:0] mem3 [logic [17:0]];

    function automatic logic [31:0] dflt(input logic [17:0] a);
        return {14'h0, a} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clock) if (bus1.mem_write) mem1[bus1.mem_addr] = bus1.mem_wdata;
    always @(posedge clock) if (bus3.mem_write) mem3[bus3.mem_addr] = bus3.mem_wdata;
    always @(negedge clock)
        bus1.mem_rdata <= mem1.exists(bus1.mem_addr) ? mem1[bus1.mem_addr] : dflt(bus1.mem_addr);
    always @(negedge clock)
        bus3.mem_rdata <= mem3.exists(bus3.mem_addr) ? mem3[bus3.mem_addr] : dflt(bus3.mem_addr);

    // Scoreboard for the MEM_LAT=1 instance.
    txn_t        sb[$];
    bit          mon_en       = 1'b0;
    bit          strobe_seen  = 1'b0;
    bit          last_owner_m = 1'b1;
    int unsigned cur_t0       = 0;
    int unsigned last_ack_cyc = 0;
    logic [31:0] m_cpu_rdata  = '0;
    logic [31:0] m_dbg_rdata  = '0;
    txn_t        me;

    always @(negedge clock) begin
        if (mon_en) begin
            check("one_ack", bus1.cpu_ack & bus1.dbg_ack, 0);
            check("one_strobe", bus1.mem_read & bus1.mem_write, 0);
            check("cpu_stall", bus1.cpu_stall, bus1.cpu_req & ~bus1.cpu_ack);
            if (bus1.mem_read || bus1.mem_write) begin
                check("strobe_expected", (sb.size() != 0) && !strobe_seen, 1);
                if (sb.size() != 0 && !strobe_seen) begin
                    me     = sb[0];
                    cur_t0 = me.chain ? last_ack_cyc + 1 : me.t0;
                    check("strobe_cycle", cyc, cur_t0 + 1);
                    check("mem_write", bus1.mem_write, me.we);
                    check("mem_read", bus1.mem_read, !me.we);
                    check("mem_byte", bus1.mem_byte, me.byte_op);
                    check("mem_addr", bus1.mem_addr, me.addr);
                    if (me.we) check("mem_wdata", bus1.mem_wdata, me.wdata);
                    strobe_seen = 1'b1;
                end
            end
            if (bus1.cpu_ack || bus1.dbg_ack) begin
                check("ack_expected", (sb.size() != 0) && strobe_seen, 1);
                if (sb.size() != 0 && strobe_seen) begin
                    me = sb.pop_front();
                    check("ack_owner", bus1.dbg_ack, me.is_dbg);
                    check("ack_cycle", cyc, cur_t0 + me.exp_lat);
                    if (!me.we) begin
                        if (me.is_dbg) m_dbg_rdata = me.exp_rdata;
                        else           m_cpu_rdata = me.exp_rdata;
                    end
                    check("cpu_rdata", bus1.cpu_rdata, m_cpu_rdata);
                    check("dbg_rdata", bus1.dbg_rdata, m_dbg_rdata);
                    last_ack_cyc = cyc;
                    strobe_seen  = 1'b0;
                end
            end
        end
    end

    function automatic txn_t mk(input bit d, input bit w, input bit b, input logic [17:0] a,
                                input logic [31:0] wd, input logic [31:0] rd);
        txn_t t;
        t.is_dbg = d; t.we = w; t.byte_op = b; t.addr = a; t.wdata = wd;
        t.exp_rdata = rd; t.exp_lat = 2; t.chain = 1'b0; t.t0 = 0;
        return t;
    endfunction

    task automatic drive(input txn_t v);
        if (v.is_dbg) begin
            bus1.dbg_we = v.we; bus1.dbg_byte = v.byte_op; bus1.dbg_addr = v.addr;
            bus1.dbg_wdata = v.wdata; bus1.dbg_req = 1'b1;
        end else begin
            bus1.cpu_we = v.we; bus1.cpu_byte = v.byte_op; bus1.cpu_addr = v.addr;
            bus1.cpu_wdata = v.wdata; bus1.cpu_req = 1'b1;
        end
    endtask

    task automatic wait_drain(input int unsigned budget);
        for (int unsigned k = 0; k < budget; k++) begin
            @(posedge clock); #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
            strobe_seen = 1'b0;
        end
    endtask

    task automatic run_txn(input txn_t v);
        txn_t e;
        e = v;
        e.t0 = cyc;
        sb.push_back(e);
        last_owner_m = v.is_dbg;
        drive(v);
        wait_drain(20);
        bus1.cpu_req = 1'b0;
        bus1.dbg_req = 1'b0;
    endtask

    task automatic d3_dbg_load(input string tag, input logic [17:0] addr,
                               input logic [31:0] exp, input logic [31:0] exp_cpu);
        int unsigned t0, s_cyc, a_cyc, n_str;
        bus3.dbg_we = 1'b0; bus3.dbg_byte = 1'b0; bus3.dbg_addr = addr; bus3.dbg_req = 1'b1;
        t0 = cyc; s_cyc = 0; a_cyc = 0; n_str = 0;
        for (int unsigned k = 0; k < 12; k++) begin
            @(negedge clock);
            if (bus3.mem_read) begin
                n_str++;
                if (s_cyc == 0) s_cyc = cyc;
            end
            if (bus3.dbg_ack) begin
                a_cyc = cyc;
                break;
            end
        end
        check({tag, "_strobe_cycle"}, s_cyc, t0 + 1);
        check({tag, "_strobe_count"}, n_str, 1);
        check({tag, "_ack_cycle"}, a_cyc, t0 + 4);
        check({tag, "_dbg_rdata"}, bus3.dbg_rdata, exp);
        check({tag, "_cpu_rdata"}, bus3.cpu_rdata, exp_cpu);
        @(posedge clock); #1;
        bus3.dbg_req = 1'b0;
    endtask

    initial begin
        txn_t        vec[10];
        txn_t        tc, td, e;
        int unsigned cnt;
        bit          w;

        vec[0] = mk(0, 1, 0, 18'h00010, 32'hDEAD_BEEF, 32'h0);
        vec[1] = mk(0, 0, 0, 18'h00010, 32'h0,         32'hDEAD_BEEF);
        vec[2] = mk(0, 1, 1, 18'h00013, 32'h0000_00A5, 32'h0);
        vec[3] = mk(1, 1, 0, 18'h00200, 32'h1234_5678, 32'h0);
        vec[4] = mk(1, 0, 0, 18'h00200, 32'h0,         32'h1234_5678);
        vec[5] = mk(0, 0, 0, 18'h00013, 32'h0,         32'h0000_00A5);
        vec[6] = mk(1, 0, 0, 18'h00010, 32'h0,         32'hDEAD_BEEF);
        vec[7] = mk(0, 1, 0, 18'h3FFFF, 32'hFFFF_FFFF, 32'h0);
        vec[8] = mk(0, 0, 0, 18'h00100, 32'h0,         32'h5A5A_0100);
        vec[9] = mk(1, 0, 0, 18'h3FFFF, 32'h0,         32'hFFFF_FFFF);

        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_byte = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_byte = 0; bus1.dbg_addr = '0; bus1.dbg_wdata = '0;
        bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_byte = 0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.dbg_req = 0; bus3.dbg_we = 0; bus3.dbg_byte = 0; bus3.dbg_addr = '0; bus3.dbg_wdata = '0;
        mem3[18'h3FFFC] = 32'hCAFE_F00D;
        rst_n = 1'b0; rst3_n = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        bus1.cpu_req = 1'b1;
        #1;
        check("rst_cpu_ack", bus1.cpu_ack, 0);
        check("rst_dbg_ack", bus1.dbg_ack, 0);
        check("rst_mem_read", bus1.mem_read, 0);
        check("rst_mem_write", bus1.mem_write, 0);
        check("rst_mem_addr", bus1.mem_addr, 0);
        check("rst_cpu_rdata", bus1.cpu_rdata, 0);
        check("rst_dbg_rdata", bus1.dbg_rdata, 0);
        check("rst_stall", bus1.cpu_stall, 1);
        bus1.cpu_req = 1'b0;

        @(posedge clock); #1;
        rst_n = 1'b1; rst3_n = 1'b1;
        @(posedge clock); #1;
        mon_en = 1'b1;

        for (int unsigned i = 0; i < 10; i++) run_txn(vec[i]);

        // Both requesters held high for eight back-to-back transactions.
        tc = mk(0, 0, 0, 18'h00010, 32'h0, 32'hDEAD_BEEF);
        td = mk(1, 0, 0, 18'h00200, 32'h0, 32'h1234_5678);
        for (int unsigned i = 0; i < 8; i++) begin
`ifdef DATA_MEM_ARB_RR_EN
            w = !last_owner_m;
`else
            w = 1'b0;
`endif
            e = w ? td : tc;
            e.chain = (i != 0);
            e.t0 = cyc;
            sb.push_back(e);
            last_owner_m = w;
        end
        drive(tc);
        drive(td);
        wait_drain(40);
        bus1.cpu_req = 1'b0;
        bus1.dbg_req = 1'b0;

        // CPU alone, held high: one ack every three cycles.
        for (int unsigned i = 0; i < 4; i++) begin
            e = mk(0, 0, 0, 18'h00013, 32'h0, 32'h0000_00A5);
            e.chain = (i != 0);
            e.t0 = cyc;
            sb.push_back(e);
        end
        last_owner_m = 1'b0;
        drive(mk(0, 0, 0, 18'h00013, 32'h0, 32'h0000_00A5));
        wait_drain(20);
        bus1.cpu_req = 1'b0;

        @(posedge clock); #1;
        d3_dbg_load("lat3", 18'h3FFFC, 32'hCAFE_F00D, 32'h0);

        // Reset asserted while the MEM_LAT=3 instance sits in WAIT.
        bus3.cpu_we = 1'b1; bus3.cpu_addr = 18'h00040; bus3.cpu_wdata = 32'h1111_1111; bus3.cpu_req = 1'b1;
        @(posedge clock); #1;
        check("wait_issue_write", bus3.mem_write, 1);
        @(posedge clock); #1;
        check("wait_strobe_low", bus3.mem_write, 0);
        rst3_n = 1'b0;
        #1;
        check("wait_rst_cpu_ack", bus3.cpu_ack, 0);
        check("wait_rst_dbg_ack", bus3.dbg_ack, 0);
        check("wait_rst_strobes", bus3.mem_read | bus3.mem_write, 0);
        check("wait_rst_dbg_rdata", bus3.dbg_rdata, 0);
        bus3.cpu_req = 1'b0;
        @(posedge clock); #1;
        rst3_n = 1'b1;
        cnt = 0;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clock);
            if (bus3.cpu_ack || bus3.dbg_ack || bus3.mem_write || bus3.mem_read) cnt++;
        end
        check("post_rst_quiet", cnt, 0);

        // Reset asserted in the ISSUE cycle drops the write strobe immediately.
        @(posedge clock); #1;
        bus3.cpu_addr = 18'h00044; bus3.cpu_req = 1'b1;
        @(posedge clock); #1;
        check("issue_write", bus3.mem_write, 1);
        check("issue_addr", bus3.mem_addr, 18'h00044);
        #2;
        rst3_n = 1'b0;
        #1;
        check("issue_rst_write", bus3.mem_write, 0);
        check("issue_rst_addr", bus3.mem_addr, 0);
        bus3.cpu_req = 1'b0;
        @(posedge clock); #1;
        rst3_n = 1'b1;
        @(posedge clock); #1;
        d3_dbg_load("post_rst", 18'h3FFFC, 32'hCAFE_F00D, 32'h0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
